// File: rtl/wb_grf.sv
// Writeback-stage register file: decodes the W-stage instruction into a
// destination/source pair, commits the result into a 32x32 register file
// and forwards the in-flight write to the two combinational read ports.
module wb_grf #(
    parameter bit FWD_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] W_instr,
    input  logic [31:0] W_pc,
    input  logic [31:0] W_ALU,
    input  logic [31:0] W_DM,
    input  logic [31:0] W_HILO,
    input  logic [31:0] W_EXT,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    output logic        wb_en,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic [31:0] wb_count
);
    typedef enum logic [2:0] {
        SRC_NONE, SRC_ALU, SRC_HILO, SRC_PC8, SRC_EXT, SRC_DM
    } src_e;

    src_e        src;
    logic [4:0]  dst;
    logic [31:0] sel_data;
    logic [31:0] regs [32];
    logic [31:0] cnt_q;

    wire [5:0]  op     = W_instr[31:26];
    wire [5:0]  funct  = W_instr[5:0];
    wire [4:0]  rt     = W_instr[20:16];
    wire [4:0]  rd     = W_instr[15:11];
    wire [31:0] pc8    = W_pc + 32'd8;
    // rs field and shamt play no part in writeback selection
    wire        unused_fields = ^{W_instr[25:21], W_instr[10:6]};

    // Decode op/funct into result source and destination register
    always_comb begin
        src = SRC_NONE;
        dst = '0;
        case (op)
            6'h00: begin
                case (funct)
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h2B, 6'h00: begin
                        src = SRC_ALU;
                        dst = rd;
                    end
                    6'h10, 6'h12: begin
                        src = SRC_HILO;
                        dst = rd;
                    end
                    6'h09: begin
                        src = SRC_PC8;
                        dst = rd;
                    end
                    default: ;
                endcase
            end
            6'h08, 6'h09, 6'h0C, 6'h0D: begin
                src = SRC_ALU;
                dst = rt;
            end
            6'h0F: begin
                src = SRC_EXT;
                dst = rt;
            end
            6'h23, 6'h20, 6'h21, 6'h24, 6'h25: begin
                src = SRC_DM;
                dst = rt;
            end
            6'h03: begin
                src = SRC_PC8;
                dst = 5'd31;
            end
            default: ;
        endcase
    end

    // Select write data; non-writing encodings drive zero
    always_comb begin
        sel_data = '0;
        case (src)
            SRC_ALU:  sel_data = W_ALU;
            SRC_HILO: sel_data = W_HILO;
            SRC_PC8:  sel_data = pc8;
            SRC_EXT:  sel_data = W_EXT;
            SRC_DM:   sel_data = W_DM;
            default:  sel_data = '0;
        endcase
    end

    // A write to $0 still shows its data but never commits
    assign wb_en    = (src != SRC_NONE) && (dst != 5'd0);
    assign wb_addr  = wb_en ? dst : 5'd0;
    assign wb_data  = sel_data;
    assign wb_count = cnt_q;

    // Register array: cleared by reset, written on commit ($0 is never a target)
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wb_en) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Committed-write counter, saturating at all ones
    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else if (wb_en && (cnt_q != '1))
            cnt_q <= cnt_q + 32'd1;
    end

    // Two independent read ports with optional same-cycle bypass
    logic [1:0][4:0]  rd_addr;
    logic [1:0][31:0] rd_data;
    assign rd_addr = {rt_addr, rs_addr};

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic byp;
        assign byp        = FWD_EN && wb_en && (rd_addr[p] == wb_addr);
        assign rd_data[p] = (rd_addr[p] == 5'd0) ? 32'd0 :
                            byp                  ? wb_data : regs[rd_addr[p]];
    end

    assign rs_data = rd_data[0];
    assign rt_data = rd_data[1];
endmodule

// File: doc/wb_grf.md
WB_GRF -- requirements
Module: wb_grf

Interface
REQ-001 SHALL have parameter FWD_EN, default 1, enabling same-cycle write-to-read bypass.
REQ-002 SHALL have clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have W_instr  input  32  writeback-stage instruction word.
REQ-005 SHALL have W_pc  input  32  writeback-stage instruction PC.
REQ-006 SHALL have W_ALU  input  32  ALU result.
REQ-007 SHALL have W_DM  input  32  load data, already extended.
REQ-008 SHALL have W_HILO  input  32  HI/LO read value.
REQ-009 SHALL have W_EXT  input  32  extended immediate.
REQ-010 SHALL have rs_addr  input  5  and rt_addr  input  5  read-port addresses.
REQ-011 SHALL have rs_data  output  32  and rt_data  output  32  read-port data.
REQ-012 SHALL have wb_en  output  1  write commits this cycle.
REQ-013 SHALL have wb_addr  output  5  destination register.
REQ-014 SHALL have wb_data  output  32  write data, also used for forwarding.
REQ-015 SHALL have wb_count  output  32  committed-write counter.

Function
REQ-016 SHALL decode W_instr[31:26]=op and [5:0]=funct combinationally.
REQ-017 SHALL select ALU source, dest rd, for op 0x00 with funct add 0x20, addu 0x21, sub 0x22, subu 0x23, and 0x24, or 0x25, slt 0x2A, sltu 0x2B, sll 0x00.
REQ-018 SHALL select HILO source, dest rd, for op 0x00 with funct mfhi 0x10 or mflo 0x12.
REQ-019 SHALL select W_pc+8 (mod 2^32), dest rd, for op 0x00 with funct jalr 0x09.
REQ-020 SHALL select ALU source, dest rt, for addi 0x08, addiu 0x09, andi 0x0C, ori 0x0D.
REQ-021 SHALL select EXT source, dest rt, for lui 0x0F.
REQ-022 SHALL select DM source, dest rt, for lw 0x23, lb 0x20, lh 0x21, lbu 0x24, lhu 0x25.
REQ-023 SHALL select W_pc+8, dest 31, for jal 0x03.
REQ-024 SHALL treat every other encoding as non-writing: wb_en=0, wb_addr=0, wb_data=0.
REQ-025 SHALL force wb_en=0 and wb_addr=0 whenever the decoded destination is 0; wb_data remains the selected value.
REQ-026 SHALL hold 32 registers of 32 bits; register 0 SHALL always read 0 and never be written.
REQ-027 SHALL write wb_data to register wb_addr at the rising edge when wb_en=1 and reset=0.
REQ-028 SHALL provide combinational reads; when FWD_EN=1 and wb_en=1 and read address equals wb_addr (nonzero), the port SHALL return wb_data instead of stored value.
REQ-029 SHALL return stored (pre-write) value on the bypass condition when FWD_EN=0.
REQ-030 SHALL serve both read ports independently, including both equal to each other and to wb_addr.
REQ-031 SHALL increment wb_count by 1 per edge with wb_en=1, saturating at 0xFFFFFFFF.
REQ-032 SHALL give write latency of one edge: value readable from stored state at the cycle after commit.

Reset
REQ-033 SHALL clear all 32 registers and wb_count to 0 at a rising edge with reset=1.
REQ-034 SHALL suppress the register write and counter increment on any edge with reset=1, even if wb_en=1.
REQ-035 SHALL keep wb_en/wb_addr/wb_data purely combinational from W inputs during reset; instr 0x00000000 yields wb_en=0, wb_addr=0.
REQ-036 SHALL apply bypass during reset cycles per REQ-028; reads of stored state after reset SHALL return 0.

Verification
REQ-037 SHALL verify: reset, then ori $5 (0x34050000 with W_ALU=0x1234) -> wb_en=1, wb_addr=5, wb_data=0x1234; next cycle rs_addr=5 -> 0x1234; wb_count=1.
REQ-038 SHALL verify: jal at W_pc=0x00003000 -> wb_addr=31, wb_data=0x00003008; jalr rd=7 at W_pc=0xFFFFFFFC -> wb_addr=7, wb_data=0x00000004.
REQ-039 SHALL verify: addu with rd=0, W_ALU=0xDEADBEEF -> wb_en=0; rs_addr=0 reads 0; wb_count unchanged.
REQ-040 SHALL verify bypass: lw $9 with W_DM=0xCAFEF00D, rs_addr=rt_addr=9 same cycle -> both 0xCAFEF00D (FWD_EN=1); old value 0 (FWD_EN=0).
REQ-041 SHALL verify: reset asserted while mflo $3 (W_HILO=0x55) is in W -> register 3 remains 0 after edge, wb_count=0.
REQ-042 SHALL verify: force wb_count to 0xFFFFFFFF via preceding writes or backdoor, one more write -> wb_count stays 0xFFFFFFFF.
